truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 131 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input combinations of a 3-input gate and records its truth table.
// Define TT_SWEEP_COMPARE_EN to compile in the registered compare against the expected table.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [7:0] r_cnt;
    logic [7:0] r_table;
    logic [2:0] r_ins;
    logic       r_busy;
    logic       r_done;
    logic [7:0] w_table_next;

`ifdef TT_SWEEP_COMPARE_EN
    logic [7:0] r_expected;
    logic       r_match;
`else
    logic       w_unused;
    assign w_unused = ^expected;
`endif

    // Combination 000 lands in the MSB, so the table reads left to right by index.
    // NOTE: default assignment first so no path through always_comb leaves a latch.
    always_comb begin
        w_table_next = r_table;
        w_table_next[3'd7 - r_idx] = dut_out;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_cnt      <= 8'd0;
            r_table    <= 8'h00;
            r_ins      <= 3'b000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
            r_expected <= 8'h00;
            r_match    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_SETTLE;
                        r_idx      <= 3'd0;
                        r_cnt      <= 8'd0;
                        r_table    <= 8'h00;
                        r_ins      <= 3'b000;
                        r_busy     <= 1'b1;
`ifdef TT_SWEEP_COMPARE_EN
                        r_expected <= expected;
                        r_match    <= 1'b0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == LAST_SETTLE) begin
                        r_state <= S_SAMPLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    r_table <= w_table_next;
                    if (r_idx == 3'd7) begin
                        r_state <= S_DONE;
                        r_ins   <= 3'b000;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef TT_SWEEP_COMPARE_EN
                        r_match <= (w_table_next == r_expected);
`endif
                    end else begin
                        r_state <= S_SETTLE;
                        r_idx   <= r_idx + 3'd1;
                        r_ins   <= r_idx + 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in1       = r_ins[2];
    assign in2       = r_ins[1];
    assign in3       = r_ins[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;

`ifdef TT_SWEEP_COMPARE_EN
    assign match = r_match;
`else
    assign match = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE_CYCLES 4 and 1) checked every cycle
// against a timing-formula model of the sweep; honours TT_SWEEP_COMPARE_EN for match.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic [7:0] gate_f = 8'h00;   // gate output for combination i is gate_f[i]

    logic       dut_out   [2];
    logic       in1       [2];
    logic       in2       [2];
    logic       in3       [2];
    logic       busy      [2];
    logic       done      [2];
    logic       match     [2];
    logic [7:0] table_out [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_cnt [2];
    int busy_low;

    bit         active [2];
    int         acc    [2];
    logic [7:0] cap    [2];
    logic [7:0] fs     [2];
    logic       mm     [2];

    always #5 clk = ~clk;

    assign dut_out[0] = gate_f[{in1[0], in2[0], in3[0]}];
    assign dut_out[1] = gate_f[{in1[1], in2[1], in3[1]}];

    truth_table_sweeper #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_out(dut_out[0]),
        .in1(in1[0]), .in2(in2[0]), .in3(in3[0]), .busy(busy[0]), .done(done[0]),
        .table_out(table_out[0]), .match(match[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_out(dut_out[1]),
        .in1(in1[1]), .in2(in2[1]), .in3(in3[1]), .busy(busy[1]), .done(done[1]),
        .table_out(table_out[1]), .match(match[1])
    );

    function automatic int period(input int n);
        return (n == 0) ? 5 : 2;
    endfunction

    // Table after d cycles into a sweep: combination i is recorded once (i+1) periods elapsed.
    function automatic logic [7:0] model_table(input logic [7:0] f, input int p, input int d);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++)
            if ((i + 1) * p <= d) t[7 - i] = f[i];
        return t;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from inputs sampled at the edge, then compare on the falling edge.
    task automatic step();
        int p;
        int d;
        logic       e_busy;
        logic       e_done;
        logic [2:0] e_ins;
        logic [7:0] e_tbl;
        logic       e_match;
        @(posedge clk);
        cyc++;
        for (int n = 0; n < 2; n++) begin
            p = period(n);
            if (!rst_n) begin
                active[n] = 1'b0;
                cap[n]    = 8'h00;
                mm[n]     = 1'b0;
            end else begin
                if (start && (!active[n] || (cyc - 1 - acc[n]) > 8 * p)) begin
                    active[n] = 1'b1;
                    acc[n]    = cyc;
                    cap[n]    = expected;
                    fs[n]     = gate_f;
                    mm[n]     = 1'b0;
                end
                if (active[n] && (cyc - acc[n]) == 8 * p) begin
`ifdef TT_SWEEP_COMPARE_EN
                    mm[n] = (model_table(fs[n], p, 8 * p) == cap[n]);
`else
                    mm[n] = 1'b0;
`endif
                end
            end
        end
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            p       = period(n);
            d       = cyc - acc[n];
            e_busy  = active[n] && (d < 8 * p);
            e_done  = active[n] && (d == 8 * p);
            e_ins   = e_busy ? 3'(d / p) : 3'b000;
            e_tbl   = active[n] ? model_table(fs[n], p, d) : 8'h00;
            e_match = active[n] ? mm[n] : 1'b0;
            check($sformatf("busy%0d@%0d", n, cyc), {7'd0, busy[n]}, {7'd0, e_busy});
            check($sformatf("done%0d@%0d", n, cyc), {7'd0, done[n]}, {7'd0, e_done});
            check($sformatf("ins%0d@%0d", n, cyc), {5'd0, in1[n], in2[n], in3[n]}, {5'd0, e_ins});
            check($sformatf("table%0d@%0d", n, cyc), table_out[n], e_tbl);
            check($sformatf("match%0d@%0d", n, cyc), {7'd0, match[n]}, {7'd0, e_match});
            if (done[n] === 1'b1) done_cnt[n]++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    endtask

    task automatic pulse_and_run(input int cycles);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= cycles; k++) step();
    endtask

    initial begin
        logic [7:0] tbl;
        logic       exp_m;
        active[0] = 1'b0;
        active[1] = 1'b0;
        acc[0] = 0;
        acc[1] = 0;

        // Gate high at 101 and 111; stray starts at cycles 5 and 20 of the sweep.
        gate_f   = 8'b1010_0000;
        expected = 8'h05;
        do_reset();
        start = 1'b1;
        step();
        for (int k = 1; k <= 50; k++) begin
            start = (k == 5 || k == 20);
            step();
        end
        start = 1'b0;
        check("sc1_table", table_out[0], 8'h05);
        check("sc1_one_done", 8'(done_cnt[0]), 8'd1);
`ifdef TT_SWEEP_COMPARE_EN
        exp_m = 1'b1;
`else
        exp_m = 1'b0;
`endif
        check("sc1_match", {7'd0, match[0]}, {7'd0, exp_m});

        // Constant-one gate against an all-zero expectation.
        gate_f   = 8'hFF;
        expected = 8'h00;
        do_reset();
        pulse_and_run(45);
        check("sc2_table", table_out[0], 8'hFF);
        check("sc2_match", {7'd0, match[0]}, 8'd0);

        // Start held high: back-to-back sweeps with a two-cycle busy gap.
        gate_f   = 8'($urandom);
        expected = 8'($urandom);
        do_reset();
        busy_low = 0;
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (k > 0 && busy[0] === 1'b0) busy_low++;
        end
        start = 1'b0;
        for (int k = 0; k < 50; k++) step();
        check("sc3_busy_gap", 8'(busy_low), 8'd2);
        check("sc3_two_done", 8'(done_cnt[0]), 8'd2);

        // Reset at cycle 17 of a sweep aborts it.
        gate_f   = 8'($urandom);
        expected = 8'($urandom);
        do_reset();
        pulse_and_run(16);
        done_cnt[0] = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("sc4_table", table_out[0], 8'h00);
        check("sc4_busy", {7'd0, busy[0]}, 8'd0);
        for (int k = 0; k < 40; k++) step();
        check("sc4_no_done", 8'(done_cnt[0]), 8'd0);

        // 3-input AND gate.
        gate_f   = 8'h80;
        expected = 8'h01;
        do_reset();
        pulse_and_run(45);
        check("sc5_table4", table_out[0], 8'h01);
        check("sc5_table1", table_out[1], 8'h01);

        // Random gates, expectation matching about half the time.
        for (int s = 0; s < 6; s++) begin
            gate_f = 8'($urandom);
            tbl = 8'h00;
            for (int i = 0; i < 8; i++) tbl[7 - i] = gate_f[i];
            expected = ($urandom_range(0, 1) == 1) ? tbl : 8'($urandom);
            pulse_and_run(45);
            check($sformatf("rnd%0d_table", s), table_out[0], tbl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
